// File: rtl/rr_arbiter16.sv
// rr_arbiter16: sixteen-input round-robin arbiter feeding a 16x4 encoder.
// Registers a one-hot (or all-zero) grant plus an enable, holds each grant
// until the grantee releases it or the hold timeout fires, and always
// inserts one idle cycle between consecutive grants.
module rr_arbiter16 #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [0:15] req,
   input  logic        done,
   output logic [0:15] grant,
   output logic        grant_en,
   output logic        timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Hold limit truncated to the counter width; HOLD_ON disables the timeout when zero.
   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
   localparam bit         HOLD_ON  = (HOLD_MAX != 32'd0);

   // Round-robin search: first set bit at p, p+1, ... wrapping mod 16.
   // Result is {found, index}.
   function automatic logic [4:0] rr_pick(input logic [0:15] r, input logic [3:0] p);
      logic [4:0] res;
      logic [3:0] idx;
      res = 5'd0;
      for (int k = 0; k < 16; k++) begin
         idx = p + 4'(k);
         if (!res[4] && r[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // One-hot vector with requester idx set (bit i belongs to requester i).
   function automatic logic [0:15] one_hot(input logic [3:0] idx);
      logic [0:15] v;
      v      = 16'h0000;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Saturating increment for the hold counter; it must never wrap to zero.
   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   state_e      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic [3:0]  gid_q, gid_d;
   logic [0:15] grant_q, grant_d;
   logic        grant_en_q, grant_en_d;
   logic        timeout_q, timeout_d;

   logic [4:0]  pick_s;
   logic        rel_s;
   logic        rel_to_s;

   assign pick_s = rr_pick(req, ptr_q);

   // Release decision while a grant is active, in priority order:
   // done, requester withdrew, then hold timeout.
   always_comb begin
      rel_s    = 1'b0;
      rel_to_s = 1'b0;
      if (state_q == GRANT) begin
         if (done) begin
            rel_s = 1'b1;
         end else if (!req[gid_q]) begin
            rel_s = 1'b1;
         end else if (HOLD_ON && (hold_cnt_q == HOLD_LIM)) begin
            rel_s    = 1'b1;
            rel_to_s = 1'b1;
         end else begin
            rel_s    = 1'b0;
            rel_to_s = 1'b0;
         end
      end else begin
         rel_s    = 1'b0;
         rel_to_s = 1'b0;
      end
   end

   // Next-state computation for the FSM, pointer, hold counter and outputs.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      gid_d      = gid_q;
      grant_d    = grant_q;
      grant_en_d = grant_en_q;
      timeout_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_s[4]) begin
               state_d    = GRANT;
               gid_d      = pick_s[3:0];
               grant_d    = one_hot(pick_s[3:0]);
               grant_en_d = 1'b1;
               hold_cnt_d = 8'd1;
            end else begin
               grant_d    = 16'h0000;
               grant_en_d = 1'b0;
            end
         end
         GRANT: begin
            if (rel_s) begin
               // Always drop to IDLE so the encoder sees a zero gap between grants.
               state_d    = IDLE;
               grant_d    = 16'h0000;
               grant_en_d = 1'b0;
               ptr_d      = gid_q + 4'd1;
               timeout_d  = rel_to_s;
            end else begin
               hold_cnt_d = sat_inc(hold_cnt_q);
            end
         end
         default: begin
            state_d    = IDLE;
            grant_d    = 16'h0000;
            grant_en_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= 4'd0;
         hold_cnt_q <= 8'd0;
         gid_q      <= 4'd0;
         grant_q    <= 16'h0000;
         grant_en_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gid_q      <= gid_d;
         grant_q    <= grant_d;
         grant_en_q <= grant_en_d;
         timeout_q  <= timeout_d;
      end
   end

   assign grant    = grant_q;
   assign grant_en = grant_en_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter16;

   localparam int HOLD = 4;

   logic        clk;
   logic        rst_n;
   logic [0:15] req;
   logic        done;
   logic [0:15] grant;
   logic        grant_en;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   bit          m_busy;
   int          m_owner;
   int          m_held;
   int          m_start;
   logic [0:15] m_grant;
   logic        m_to;

   rr_arbiter16 #(.HOLD_MAX(HOLD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .done     (done),
      .grant    (grant),
      .grant_en (grant_en),
      .timeout  (timeout)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [0:15] oh(input int i);
      logic [0:15] v;
      v    = 16'h0000;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_held  = 0;
      m_start = 0;
      m_grant = 16'h0000;
      m_to    = 1'b0;
   endtask

   // One clock edge of the arbitration rules, using the inputs seen at that edge.
   task automatic model_edge(input logic [0:15] r, input logic d);
      bit rel;
      bit to;
      if (!m_busy) begin
         m_to    = 1'b0;
         m_grant = 16'h0000;
         for (int k = 0; k < 16; k++) begin
            int i;
            i = (m_start + k) % 16;
            if (!m_busy && r[i]) begin
               m_busy  = 1'b1;
               m_owner = i;
               m_held  = 1;
               m_grant = oh(i);
            end
         end
      end else begin
         rel = 1'b0;
         to  = 1'b0;
         if (d) rel = 1'b1;
         else if (!r[m_owner]) rel = 1'b1;
         else if (HOLD > 0 && m_held == HOLD) begin
            rel = 1'b1;
            to  = 1'b1;
         end else if (m_held < 255) m_held = m_held + 1;
         if (rel) begin
            m_busy  = 1'b0;
            m_grant = 16'h0000;
            m_start = (m_owner + 1) % 16;
         end
         m_to = to;
      end
   endtask

   task automatic compare_model(input string tag);
      check_eq({tag, "_grant"}, grant, m_grant);
      check_eq({tag, "_en"}, 16'(grant_en), 16'(m_grant != 16'h0000));
      check_eq({tag, "_to"}, 16'(timeout), 16'(m_to));
   endtask

   // Drive inputs at a falling edge, advance one rising edge, compare at the next falling edge.
   task automatic step(input logic [0:15] r, input logic d, input string tag);
      req  = r;
      done = d;
      @(posedge clk);
      model_edge(r, d);
      @(negedge clk);
      compare_model(tag);
   endtask

   initial begin
      logic [0:15] rr;
      rst_n = 1'b0;
      req   = 16'hFFFF;
      done  = 1'b0;
      model_reset();

      // Reset held with every request active.
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_grant", grant, 16'h0000);
      check_eq("rst_en", 16'(grant_en), 16'h0000);
      check_eq("rst_to", 16'(timeout), 16'h0000);
      rst_n = 1'b1;

      // First grant after reset goes to requester 0.
      step(16'hFFFF, 1'b0, "first");
      check_eq("first_is0", grant, oh(0));
      step(16'hFFFF, 1'b1, "first_rel");
      step(16'h0000, 1'b0, "idle");
      check_eq("idle_zero", grant, 16'h0000);

      // Single request, done release and re-grant.
      step(oh(5), 1'b0, "single");
      check_eq("single_is5", grant, oh(5));
      check_eq("single_en", 16'(grant_en), 16'h0001);
      step(oh(5), 1'b1, "single_done");
      check_eq("single_gap", grant, 16'h0000);
      step(oh(5), 1'b0, "single_re");
      check_eq("single_re5", grant, oh(5));
      step(16'h0000, 1'b0, "single_wd");

      // Bring the pointer back to 0 via requester 15.
      step(oh(15), 1'b0, "p15");
      step(16'h0000, 1'b0, "p15_wd");

      // Full rotation with all requesting.
      for (int i = 0; i <= 16; i++) begin
         step(16'hFFFF, 1'b0, "rot");
         check_eq("rot_order", grant, oh(i % 16));
         step(16'hFFFF, 1'b1, "rot_rel");
         check_eq("rot_gap", grant, 16'h0000);
      end

      // Wrap-around: after requester 9, pointer is 10; 12 wins before 3.
      step(oh(9), 1'b0, "w9");
      step(oh(9), 1'b1, "w9_rel");
      step(oh(3) | oh(12), 1'b0, "wrap");
      check_eq("wrap_12", grant, oh(12));
      step(oh(3) | oh(12), 1'b1, "wrap_rel");
      step(oh(3) | oh(12), 1'b0, "wrap2");
      check_eq("wrap_3", grant, oh(3));
      step(16'h0000, 1'b0, "wrap_wd");

      // Timeout: grant 7 for exactly HOLD cycles, then a one-cycle timeout pulse.
      for (int c = 1; c <= HOLD; c++) begin
         step(oh(7), 1'b0, "to_hold");
         check_eq("to_held7", grant, oh(7));
         check_eq("to_low", 16'(timeout), 16'h0000);
      end
      step(oh(7), 1'b0, "to_fire");
      check_eq("to_gap", grant, 16'h0000);
      check_eq("to_pulse", 16'(timeout), 16'h0001);
      step(oh(7), 1'b0, "to_regrant");
      check_eq("to_re7", grant, oh(7));
      check_eq("to_clear", 16'(timeout), 16'h0000);
      for (int c = 2; c <= HOLD; c++) step(oh(7), 1'b0, "to2_hold");
      step(oh(7), 1'b1, "to2_done");
      check_eq("done_wins_g", grant, 16'h0000);
      check_eq("done_wins_to", 16'(timeout), 16'h0000);
      step(16'h0000, 1'b0, "to2_idle");

      // Asynchronous reset in the middle of a grant to requester 11.
      step(oh(11), 1'b0, "ar");
      check_eq("ar_is11", grant, oh(11));
      #2 rst_n = 1'b0;
      #1;
      check_eq("ar_grant", grant, 16'h0000);
      check_eq("ar_en", 16'(grant_en), 16'h0000);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(oh(2) | oh(9), 1'b0, "ar_after");
      check_eq("ar_ptr0", grant, oh(2));

      // Random traffic: sparse requests, occasional done.
      for (int n = 0; n < 800; n++) begin
         rr = 16'($urandom) & 16'($urandom);
         if ($urandom_range(0, 7) == 0) rr = 16'h0000;
         step(rr, ($urandom_range(0, 3) == 0), "rnd");
      end

      // Random traffic with steady requesters so timeouts occur often.
      rr = 16'($urandom) | 16'h0101;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 15) == 0) rr = 16'($urandom) | 16'h0010;
         step(rr, ($urandom_range(0, 9) == 0), "rnd_hold");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
